// File: rtl/time_manager.sv
// Global emulated-time manager: merges per-client next-edge times into one
// broadcast time and advances it step by step under a small run/halt FSM.
package time_settings;
  localparam int unsigned TIME_BITS = 32;
  typedef logic [TIME_BITS-1:0] time_t;
  localparam time_t TIME_MAX = '1;
endpackage

module time_manager
  import time_settings::*;
#(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  time_t                time_clocks [N_CLIENTS],
  input  logic [N_CLIENTS-1:0] client_en,
  input  logic                 start,
  input  logic                 stop,
  input  time_t                stop_time,
  output time_t                time_next,
  output time_t                emu_time,
  output logic [CNT_BITS-1:0]  step_count,
  output logic                 running,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t state, state_next;
  time_t  min_t;
  logic   any_en;
  logic   step;
  logic   err_set;

  // Minimum over enabled clients; ties collapse naturally to one value.
  always_comb begin
    min_t  = TIME_MAX;
    any_en = 1'b0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (client_en[i]) begin
        any_en = 1'b1;
        if (time_clocks[i] < min_t) min_t = time_clocks[i];
      end
    end
  end

  // Next-state and step decision.
  always_comb begin
    state_next = state;
    step       = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        if (any_en && (min_t < emu_time)) begin
          state_next = HALT;
          err_set    = 1'b1;
        end else if (stop || !any_en || (min_t > stop_time)) begin
          state_next = HALT;
        end else begin
          step = !rst;
        end
      end
      HALT: begin
        if (start && !stop && !err) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // TIME_MAX keeps every clock instance from matching when no step executes.
  assign time_next = step ? min_t : TIME_MAX;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= IDLE;
      emu_time   <= '0;
      step_count <= '0;
      err        <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      done    <= (state_next == HALT);
      if (step) begin
        emu_time <= min_t;
        if (step_count != '1) step_count <= step_count + CNT_BITS'(1);
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: doc/time_manager.md
TIME_MANAGER -- requirements
Module: time_manager

Interface
REQ-001 Parameter N_CLIENTS, default 4, number of emulated clocks whose next-edge times are merged (1..16).
REQ-002 Parameter CNT_BITS, default 32, width of the step counter.
REQ-003 Type time_t SHALL come from package time_settings; TIME_MAX denotes all-ones time_t.
REQ-004 Port clk_sys  input  1  system clock; sole clock of the block.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port time_clocks  input  time_t[N_CLIENTS]  next-edge time reported by each clock instance.
REQ-007 Port client_en  input  N_CLIENTS  per-client participation mask; 0 excludes that client from the minimum.
REQ-008 Port start  input  1  single-cycle run request.
REQ-009 Port stop  input  1  single-cycle halt request.
REQ-010 Port stop_time  input  time_t  last emulated time allowed to execute; sampled every RUN cycle.
REQ-011 Port time_next  output  time_t  global emulated time broadcast to all clock instances.
REQ-012 Port emu_time  output  time_t  registered time of the last executed step.
REQ-013 Port step_count  output  CNT_BITS  number of executed steps.
REQ-014 Port running  output  1  high in RUN state.
REQ-015 Port done  output  1  high in HALT state.
REQ-016 Port err  output  1  sticky time-went-backwards flag.

Function
REQ-017 States: IDLE, RUN, HALT; encoding is implementation choice.
REQ-018 min_t SHALL be the unsigned minimum of time_clocks[i] over i with client_en[i]=1, computed combinationally in the same cycle; any_en = OR of client_en.
REQ-019 In RUN with step_ok = any_en && min_t <= stop_time && min_t >= emu_time && !stop: time_next = min_t combinationally; at the clock edge emu_time <= min_t and step_count increments.
REQ-020 In every other state/condition time_next SHALL equal TIME_MAX so no clock instance asserts time_eq.
REQ-021 step_count SHALL saturate at all-ones and not wrap.
REQ-022 IDLE -> RUN on start=1 && stop=0; start and stop in the same cycle leaves the block in IDLE.
REQ-023 RUN -> HALT on stop=1, or any_en=0, or min_t > stop_time; that cycle executes no step.
REQ-024 RUN -> HALT with err <= 1 when any_en=1 and min_t < emu_time; no step executed.
REQ-025 min_t == emu_time is legal (simultaneous edges in consecutive cycles) and SHALL execute a step.
REQ-026 HALT -> RUN on start=1 && stop=0 && err=0, preserving emu_time and step_count (resume with a new stop_time); HALT is terminal while err=1.
REQ-027 Ties among clients SHALL produce the common minimum once; no per-client arbitration.
REQ-028 running and done SHALL be registered state decodes, with no combinational path from inputs.

Reset
REQ-029 On rst=1 at a clk_sys edge: state IDLE, emu_time 0, step_count 0, err 0, running 0, done 0; time_next reads TIME_MAX from the following cycle.
REQ-030 rst SHALL take priority over start/stop and abort a RUN immediately, with no step executed in that cycle.

Verification
REQ-031 N=2, en=11, time_clocks {10,25}, stop_time 100, start pulse -> next cycle time_next=10, emu_time=10 after edge, step_count=1.
REQ-032 Clock models with INC 3 and 5 from 0, stop_time 15 -> steps at 0,3,5,6,9,10,12,15, step_count=8, then done=1 with time_next=TIME_MAX.
REQ-033 In RUN, drive client0 time 4 after emu_time=7 -> err=1, done=1, no step_count change; a later start is ignored.
REQ-034 start and stop asserted together in IDLE -> remains IDLE, running=0, time_next=TIME_MAX.
REQ-035 rst asserted mid-RUN at emu_time=42 -> next cycle IDLE, emu_time=0, step_count=0, err=0.
REQ-036 client_en=00 on the start cycle -> one RUN cycle, then HALT with step_count=0; CNT_BITS=4 run of 20 steps -> step_count holds at 15.
